// File: rtl/vga_mux_pkg.sv
// Shared types and constants for the layered object mux.
package vga_mux_pkg;

    localparam int          RGB_W_DEF       = 8;
    localparam logic [7:0]  TRANSPARENT_DEF = 8'hFF;
    localparam logic [2:0]  BG_LAYER_ID     = 3'd7;

    typedef logic [7:0] rgb332_t;

    // RRRGGGBB -> 24-bit {r,g,b}; the LSB of each field is replicated into the low bits
    function automatic logic [23:0] rgb332_expand(input rgb332_t c);
        return {c[7:5], {5{c[5]}}, c[4:2], {5{c[2]}}, c[1:0], {6{c[0]}}};
    endfunction

endpackage

// File: rtl/layer_priority_encoder.sv
// Lowest-index-wins encoder over the active-layer vector.
module layer_priority_encoder #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_active,
    output logic [2:0]   o_sel,
    output logic         o_any
);

    // scan from the top so the lowest active index is the last assignment
    always_comb begin
        o_sel = '0;
        o_any = |i_active;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_active[i]) o_sel = 3'(i);
        end
    end

endmodule

// File: rtl/layered_objects_mux.sv
// Priority mux of object layers over background with a two-stage pipeline,
// transparent-colour keying and player-vs-layer collision tracking.
module layered_objects_mux
    import vga_mux_pkg::*;
#(
    parameter int               NUM_LAYERS  = 4,
    parameter int               RGB_W       = RGB_W_DEF,
    parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pixelValid,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       layerEnable,
    input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
    input  logic [NUM_LAYERS-1:0]       layerDrawingRequest,
    input  logic [RGB_W-1:0]            backGroundRGB,
    output logic [7:0]                  redOut,
    output logic [7:0]                  greenOut,
    output logic [7:0]                  blueOut,
    output logic                        pixelValidOut,
    output logic [2:0]                  winningLayer,
    output logic [NUM_LAYERS-1:0]       collisionPulse,
    output logic [NUM_LAYERS-1:0]       frameCollisions
);

    // winningLayer reserves code 7 for background, so at most 7 object layers
    generate
        if (NUM_LAYERS < 2 || NUM_LAYERS > 7) begin : g_bad_layers
            $error("layered_objects_mux: NUM_LAYERS must be in 2..7");
        end
        if (RGB_W != 8) begin : g_bad_rgb
            $error("layered_objects_mux: RGB_W must be 8 (RRRGGGBB)");
        end
    endgenerate

    logic [RGB_W-1:0]      w_layer [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] w_active;
    logic [NUM_LAYERS-1:0] w_hit;
    logic [2:0]            w_sel;
    logic                  w_any;
    logic [RGB_W-1:0]      w_sel_rgb;
    logic [2:0]            w_win;

    logic [RGB_W-1:0]      r1_rgb;
    logic                  r1_valid;
    logic [2:0]            r1_win;
    logic [NUM_LAYERS-1:0] r1_hit;

    logic [23:0]           r2_rgb;
    logic                  r2_valid;
    logic [2:0]            r2_win;
    logic [NUM_LAYERS-1:0] r2_hit;

    logic [NUM_LAYERS-1:0] r_acc;
    logic [NUM_LAYERS-1:0] r_frame;

    // unpack layer colours and qualify each layer as actually drawing this pixel
    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            w_layer[i]  = layerRGB[i*RGB_W +: RGB_W];
            w_active[i] = layerDrawingRequest[i] & layerEnable[i] &
                          (w_layer[i] != TRANSPARENT) & pixelValid;
        end
    end

    layer_priority_encoder #(
        .N (NUM_LAYERS)
    ) u_prio (
        .i_active (w_active),
        .o_sel    (w_sel),
        .o_any    (w_any)
    );

    // winning colour, blanked outside the visible area
    always_comb begin
        w_sel_rgb = backGroundRGB;
        if (w_any) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (w_sel == 3'(i)) w_sel_rgb = w_layer[i];
            end
        end
        if (!pixelValid) w_sel_rgb = '0;
        w_win = w_any ? w_sel : BG_LAYER_ID;
    end

    // player (layer 0) overlapping any other drawn layer; bit 0 never set
    always_comb begin
        w_hit = '0;
        for (int i = 1; i < NUM_LAYERS; i++) begin
            w_hit[i] = w_active[0] & w_active[i];
        end
    end

    // stage 1: selection result
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_rgb   <= '0;
            r1_valid <= 1'b0;
            r1_win   <= '0;
            r1_hit   <= '0;
        end else begin
            r1_rgb   <= w_sel_rgb;
            r1_valid <= pixelValid;
            r1_win   <= w_win;
            r1_hit   <= w_hit;
        end
    end

    // stage 2: colour expansion and aligned side-band outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r2_rgb   <= '0;
            r2_valid <= 1'b0;
            r2_win   <= '0;
            r2_hit   <= '0;
        end else begin
            r2_rgb   <= rgb332_expand(r1_rgb);
            r2_valid <= r1_valid;
            r2_win   <= r1_win;
            r2_hit   <= r1_hit;
        end
    end

    // sticky per-frame collision flags; the first pixel's hit closes the old frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= '0;
            r_frame <= '0;
        end else if (startOfFrame) begin
            r_frame <= r_acc | w_hit;
            r_acc   <= '0;
        end else begin
            r_acc   <= r_acc | w_hit;
        end
    end

    assign redOut          = r2_rgb[23:16];
    assign greenOut        = r2_rgb[15:8];
    assign blueOut         = r2_rgb[7:0];
    assign pixelValidOut   = r2_valid;
    assign winningLayer    = r2_win;
    assign collisionPulse  = r2_hit;
    assign frameCollisions = r_frame;

endmodule
